apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers toward our memory-backed APB slave. It returns read data and an error flag on a valid/ready response channel. Wait states are bounded by a timeout counter. It is the stage directly upstream of the APB slave and drives that slave's P_* inputs.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr and P_addr.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort. 0 disables the timeout.
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- P_clk  input  1  clock; all state updates on the rising edge.
- P_rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte/word address, forwarded verbatim.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr  output  1  P_slverr of the completing transfer, or 1 on timeout.
- rsp_timeout  output  1  transfer aborted by the timeout.
- P_addr, P_write, P_wdata  output  ADDR_WIDTH/1/DATA_WIDTH  APB request fields.
- P_selx  output  1  APB select.
- P_enable  output  1  APB enable.
- P_ready  input  1  slave completion.
- P_slverr  input  1  slave error.
- P_rdata  input  DATA_WIDTH  slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready:
  - latch write/addr/wdata into P_write/P_addr/P_wdata;
  - set P_selx=1;
  - go to SETUP.
- SETUP: P_selx=1, P_enable=0. Unconditionally go to ACCESS and set P_enable=1; clear the wait counter.
- ACCESS: P_selx=1, P_enable=1. Sample P_ready each cycle.
  - P_ready=1: capture rsp_rdata (P_rdata for reads, 0 for writes) and rsp_slverr=P_slverr; rsp_timeout=0; drop P_selx/P_enable; go to RESP.
  - P_ready=0 and counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0): abort with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; drop P_selx/P_enable; go to RESP.
  - Otherwise increment the counter and stay.
  - If P_ready=1 arrives in the timeout cycle, P_ready wins.
- RESP: rsp_valid=1, response fields stable. On rsp_ready, go to IDLE; rsp_valid drops on the same edge.
- P_addr, P_write and P_wdata are stable from SETUP through the last ACCESS cycle. They retain their last value while idle.
- Exactly one transfer is outstanding; cmd_ready=0 in SETUP, ACCESS and RESP.

## Timing
- All outputs are registered. Reset values: cmd_ready=0 in the reset cycle and 1 afterwards (IDLE). Every other output is 0: rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, P_selx, P_enable, P_write, P_addr, P_wdata.
- Command accepted at edge N:
  - SETUP visible in cycle N+1;
  - ACCESS from N+2;
  - zero-wait P_ready at N+2 gives rsp_valid at N+3;
  - with rsp_ready=1 at N+3, cmd_ready=1 at N+4.
- Back-to-back throughput: one transfer per 4 cycles.
- Each wait state adds 1 cycle. A timeout gives rsp_valid exactly TIMEOUT_CYCLES+2 cycles after acceptance.
- Reset mid-transfer: at the next edge the FSM goes to IDLE, P_selx/P_enable go to 0, and any pending response is discarded (rsp_valid=0).
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; it never wraps.

## Structure
- apb_pkg holds:
  - apb_master_state_t (IDLE, SETUP, ACCESS, RESP as 2-bit logic enum);
  - APB_ADDR_WIDTH and APB_DATA_WIDTH defaults.
- One natural sub-module, apb_wait_timer: clear, enable, expired output, parameterised by TIMEOUT_CYCLES. The FSM and datapath registers stay in apb_master.

## Test plan
- Write 0x0000_0005 <- 0xDEAD_BEEF with zero-wait slave -> P_selx=1/P_enable=0 at N+1, P_enable=1 at N+2, rsp_valid at N+3 with rsp_slverr=0, rsp_rdata=0.
- Read 0x0000_0005 after that write -> rsp_rdata=0xDEAD_BEEF at N+3. P_addr and P_write are stable across SETUP/ACCESS.
- Slave stalls 3 cycles, then P_ready with P_slverr=1 -> rsp_valid at N+6, rsp_slverr=1, rsp_timeout=0.
- Slave never asserts P_ready, TIMEOUT_CYCLES=16 -> rsp_valid at N+18, rsp_slverr=1, rsp_timeout=1, P_selx=0 in the same cycle.
- rsp_ready held low 5 cycles with cmd_valid high -> response fields stable and cmd_ready=0 throughout; next SETUP occurs 2 cycles after rsp_ready rises.
- P_rst asserted during ACCESS -> next cycle P_selx=0, P_enable=0, rsp_valid=0, cmd_ready=1 once reset is released.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its wait timer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_master_state_t;

   localparam int APB_ADDR_WIDTH = 32;
   localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the last cycle before an abort.
// The counter saturates instead of wrapping; TIMEOUT_CYCLES=0 never expires.
module apb_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b1}};
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CNT_LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = TIMEOUT_EN && (cnt_q == CNT_LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS out,
// registered response with slave error or timeout status.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  P_clk,
   input  logic                  P_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_slverr,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] P_addr,
   output logic                  P_write,
   output logic [DATA_WIDTH-1:0] P_wdata,
   output logic                  P_selx,
   output logic                  P_enable,
   input  logic                  P_ready,
   input  logic                  P_slverr,
   input  logic [DATA_WIDTH-1:0] P_rdata
);

   apb_master_state_t state_q, state_d;

   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_slverr_q, rsp_slverr_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
   logic                  p_write_q, p_write_d;
   logic [DATA_WIDTH-1:0] p_wdata_q, p_wdata_d;
   logic                  p_selx_q, p_selx_d;
   logic                  p_enable_q, p_enable_d;

   logic timer_expired;

   // The counter restarts on the SETUP->ACCESS edge and only advances on stalled ACCESS cycles.
   apb_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (P_clk),
      .rst     (P_rst),
      .clear   (state_q == SETUP),
      .enable  ((state_q == ACCESS) && !P_ready),
      .expired (timer_expired)
   );

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_slverr_d  = rsp_slverr_q;
      rsp_timeout_d = rsp_timeout_q;
      p_addr_d      = p_addr_q;
      p_write_d     = p_write_q;
      p_wdata_d     = p_wdata_q;
      p_selx_d      = p_selx_q;
      p_enable_d    = p_enable_q;

      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               p_write_d   = cmd_write;
               p_addr_d    = cmd_addr;
               p_wdata_d   = cmd_wdata;
               p_selx_d    = 1'b1;
               cmd_ready_d = 1'b0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            p_enable_d = 1'b1;
            state_d    = ACCESS;
         end
         ACCESS: begin
            // A completion in the final counted cycle takes priority over the abort.
            if (P_ready) begin
               rsp_rdata_d   = p_write_q ? '0 : P_rdata;
               rsp_slverr_d  = P_slverr;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               p_selx_d      = 1'b0;
               p_enable_d    = 1'b0;
               state_d       = RESP;
            end else if (timer_expired) begin
               rsp_rdata_d   = '0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               p_selx_d      = 1'b0;
               p_enable_d    = 1'b0;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge P_clk) begin
      if (P_rst) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_slverr_q  <= 1'b0;
         rsp_timeout_q <= 1'b0;
         p_addr_q      <= '0;
         p_write_q     <= 1'b0;
         p_wdata_q     <= '0;
         p_selx_q      <= 1'b0;
         p_enable_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_slverr_q  <= rsp_slverr_d;
         rsp_timeout_q <= rsp_timeout_d;
         p_addr_q      <= p_addr_d;
         p_write_q     <= p_write_d;
         p_wdata_q     <= p_wdata_d;
         p_selx_q      <= p_selx_d;
         p_enable_q    <= p_enable_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_slverr  = rsp_slverr_q;
   assign rsp_timeout = rsp_timeout_q;
   assign P_addr      = p_addr_q;
   assign P_write     = p_write_q;
   assign P_wdata     = p_wdata_q;
   assign P_selx      = p_selx_q;
   assign P_enable    = p_enable_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: the bench plays the APB slave (a simple
// memory) and compares responses and cycle timing against the expected behaviour.
module tb_apb_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int NEVER = 1000;

   logic          P_clk;
   logic          P_rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic          rsp_timeout;
   logic [AW-1:0] P_addr;
   logic          P_write;
   logic [DW-1:0] P_wdata;
   logic          P_selx;
   logic          P_enable;
   logic          P_ready;
   logic          P_slverr;
   logic [DW-1:0] P_rdata;

   apb_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .P_clk       (P_clk),
      .P_rst       (P_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .P_addr      (P_addr),
      .P_write     (P_write),
      .P_wdata     (P_wdata),
      .P_selx      (P_selx),
      .P_enable    (P_enable),
      .P_ready     (P_ready),
      .P_slverr    (P_slverr),
      .P_rdata     (P_rdata)
   );

   initial P_clk = 1'b0;
   always #5 P_clk = ~P_clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Slave memory; unwritten locations read back a fixed address-derived pattern.
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5A5_A5A5;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge P_clk);
      #1;
   endtask

   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      check("cmd_ready_before_issue", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Entered in the SETUP cycle (N+1); returns in the cycle after the response handshake.
   task automatic complete(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd_val, input int waits, input bit slverr,
                           input int hold, input logic [31:0] exp_rdata, input bit exp_slverr,
                           input bit exp_to, input int exp_lat);
      int lat;
      bit got;
      check("setup_selx", P_selx, 1);
      check("setup_enable", P_enable, 0);
      check("setup_cmd_ready", cmd_ready, 0);
      check("setup_addr", P_addr, addr);
      check("setup_write", P_write, wr);
      check("setup_wdata", P_wdata, wdata);
      tick();
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 64; i++) begin
         check("access_selx", P_selx, 1);
         check("access_enable", P_enable, 1);
         check("access_addr", P_addr, addr);
         check("access_write", P_write, wr);
         check("access_no_rsp", rsp_valid, 0);
         P_ready  = (i == waits);
         P_slverr = P_ready ? slverr : 1'($urandom);
         P_rdata  = P_ready ? rd_val : $urandom;
         tick();
         P_ready = 1'b0;
         if (rsp_valid) begin
            got = 1'b1;
            lat = i + 3;
            break;
         end
      end
      if (!got) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL rsp_wait: rsp_valid never rose, expected after %0d cycles", exp_lat);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         return;
      end
      check("rsp_latency", lat, exp_lat);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_slverr", rsp_slverr, exp_slverr);
      check("rsp_timeout", rsp_timeout, exp_to);
      check("rsp_selx_low", P_selx, 0);
      check("rsp_enable_low", P_enable, 0);
      check("rsp_cmd_ready", cmd_ready, 0);
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", rsp_valid, 1);
         check("hold_rdata", rsp_rdata, exp_rdata);
         check("hold_slverr", rsp_slverr, exp_slverr);
         check("hold_timeout", rsp_timeout, exp_to);
         check("hold_cmd_ready", cmd_ready, 0);
         check("hold_selx", P_selx, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("after_rsp_valid", rsp_valid, 0);
      check("after_rsp_cmd_ready", cmd_ready, 1);
      check("after_rsp_selx", P_selx, 0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      bit          slverr;
      int          hold;
      logic [31:0] exp_rdata;
      bit          exp_slverr;
      bit          exp_to;
      int          exp_lat;
   } vec_t;

   task automatic applyStimulus(input vec_t v);
      logic [31:0] rd;
      rd = mem_read(v.addr);
      issue(v.wr, v.addr, v.wdata);
      complete(v.wr, v.addr, v.wdata, rd, v.waits, v.slverr, v.hold,
               v.exp_rdata, v.exp_slverr, v.exp_to, v.exp_lat);
      if (v.wr && (v.waits < TO) && !v.slverr) mem[v.addr] = v.wdata;
   endtask

   vec_t vecs [10];

   initial begin
      P_rst     = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      P_ready   = 1'b0;
      P_slverr  = 1'b0;
      P_rdata   = '0;

      vecs[0] = '{1'b1, 32'h5,  32'hDEAD_BEEF, 0,     1'b0, 0, 32'h0,         1'b0, 1'b0, 3};
      vecs[1] = '{1'b0, 32'h5,  32'h0,         0,     1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3};
      vecs[2] = '{1'b1, 32'h10, 32'h1234_5678, 3,     1'b1, 0, 32'h0,         1'b1, 1'b0, 6};
      vecs[3] = '{1'b0, 32'h20, 32'h0,         NEVER, 1'b0, 0, 32'h0,         1'b1, 1'b1, 18};
      vecs[4] = '{1'b0, 32'h10, 32'h0,         0,     1'b0, 2, 32'hA5A5_A5B5, 1'b0, 1'b0, 3};
      vecs[5] = '{1'b1, 32'h20, 32'hCAFE_F00D, 15,    1'b0, 0, 32'h0,         1'b0, 1'b0, 18};
      vecs[6] = '{1'b0, 32'h20, 32'h0,         2,     1'b0, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 5};
      vecs[7] = '{1'b0, 32'h5,  32'h0,         1,     1'b1, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4};
      vecs[8] = '{1'b1, 32'h30, 32'h7777_0000, 16,    1'b0, 0, 32'h0,         1'b1, 1'b1, 18};
      vecs[9] = '{1'b0, 32'h30, 32'h0,         0,     1'b0, 0, 32'hA5A5_A595, 1'b0, 1'b0, 3};

      tick();
      check("reset_cmd_ready", cmd_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_rsp_slverr", rsp_slverr, 0);
      check("reset_rsp_timeout", rsp_timeout, 0);
      check("reset_selx", P_selx, 0);
      check("reset_enable", P_enable, 0);
      check("reset_write", P_write, 0);
      check("reset_addr", P_addr, 0);
      check("reset_wdata", P_wdata, 0);
      P_rst = 1'b0;
      tick();
      check("idle_cmd_ready", cmd_ready, 1);

      for (int k = 0; k < 10; k++) applyStimulus(vecs[k]);

      // Response held back 5 cycles while the next command is already waiting.
      issue(1'b0, 32'h5, 32'h0);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h40;
      cmd_wdata = 32'h0BAD_CAFE;
      complete(1'b0, 32'h5, 32'h0, mem_read(32'h5), 0, 1'b0, 5, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);
      tick();
      cmd_valid = 1'b0;
      complete(1'b1, 32'h40, 32'h0BAD_CAFE, mem_read(32'h40), 0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 3);
      mem[32'h40] = 32'h0BAD_CAFE;

      // Reset while the slave is stalling in ACCESS.
      issue(1'b0, 32'h8, 32'h0);
      tick();
      check("prereset_enable", P_enable, 1);
      P_rst = 1'b1;
      tick();
      check("midreset_selx", P_selx, 0);
      check("midreset_enable", P_enable, 0);
      check("midreset_rsp_valid", rsp_valid, 0);
      check("midreset_cmd_ready", cmd_ready, 0);
      P_rst = 1'b0;
      tick();
      check("postreset_cmd_ready", cmd_ready, 1);
      check("postreset_rsp_valid", rsp_valid, 0);
      applyStimulus('{1'b0, 32'h40, 32'h0, 0, 1'b0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0, 3});

      // Randomized transfers against the memory/latency model.
      for (int r = 0; r < 40; r++) begin
         bit          wr, sl, to;
         logic [31:0] addr, wdata, rd, er;
         int          waits, hold, el;
         wr    = 1'($urandom_range(0, 1));
         addr  = 32'($urandom_range(0, 7)) << 2;
         wdata = $urandom;
         waits = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
         sl    = ($urandom_range(0, 3) == 0);
         hold  = $urandom_range(0, 2);
         to    = (waits >= TO);
         rd    = mem_read(addr);
         er    = (to || wr) ? 32'h0 : rd;
         el    = to ? TO + 2 : waits + 3;
         issue(wr, addr, wdata);
         complete(wr, addr, wdata, rd, waits, sl, hold, er, to || sl, to, el);
         if (wr && !to && !sl) mem[addr] = wdata;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
